// File: rtl/imem_program_loader.sv
// Loads a length-prefixed byte stream into instruction memory, then releases the CPU.
// Optional trailing XOR checksum byte is enabled by defining LOADER_CHECKSUM_EN.
`timescale 1ns/1ps
module imem_program_loader #(
   parameter int unsigned ADDR_WIDTH = 8,
   parameter logic [31:0] START_PC   = 32'd0
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  byte_valid,
   input  logic [7:0]            byte_data,
   output logic                  byte_ready,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [31:0]           imem_wdata,
   output logic                  cpu_reset,
   output logic                  start,
   output logic [31:0]           program_counter,
   output logic                  load_done,
   output logic                  error
);

   localparam int unsigned CW = 17;
   localparam int unsigned IW = ADDR_WIDTH + 1;
   localparam logic [CW-1:0] CAPACITY = CW'(1) << ADDR_WIDTH;

   typedef enum logic [2:0] {
      S_LEN_HI = 3'd0,
      S_LEN_LO = 3'd1,
      S_DATA   = 3'd2,
`ifdef LOADER_CHECKSUM_EN
      S_CHK    = 3'd3,
`endif
      S_DONE   = 3'd4,
      S_RUN    = 3'd5,
      S_ERROR  = 3'd6
   } state_e;

`ifdef LOADER_CHECKSUM_EN
   localparam state_e S_TAIL = S_CHK;
`else
   localparam state_e S_TAIL = S_DONE;
`endif

   state_e                state_q, state_d;
   logic [15:0]           count_q, count_d;
   logic [IW-1:0]         word_idx_q, word_idx_d;
   logic [1:0]            byte_cnt_q, byte_cnt_d;
   logic [23:0]           asm_q, asm_d;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]            xor_q, xor_d;
`endif
   logic                  byte_ready_q, byte_ready_d;
   logic                  imem_we_q, imem_we_d;
   logic [ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
   logic [31:0]           imem_wdata_q, imem_wdata_d;
   logic                  cpu_reset_q, cpu_reset_d;
   logic                  start_q, start_d;
   logic                  load_done_q, load_done_d;
   logic                  error_q, error_d;

   logic                  accept_c;
   logic [15:0]           len_c;
   logic                  word_done_c;
   logic                  last_word_c;

   assign accept_c    = byte_valid && byte_ready_q;
   assign len_c       = {count_q[15:8], byte_data};
   assign word_done_c = (byte_cnt_q == 2'd3);
   assign last_word_c = ((CW'(word_idx_q) + CW'(1)) == CW'(count_q));

   // State register
   always_ff @(posedge clock) begin
      if (reset) state_q <= S_LEN_HI;
      else       state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_LEN_HI: if (accept_c) state_d = S_LEN_LO;
         S_LEN_LO: begin
            if (accept_c) begin
               if (CW'(len_c) > CAPACITY) state_d = S_ERROR;
               else if (len_c == 16'd0)   state_d = S_TAIL;
               else                       state_d = S_DATA;
            end
         end
         S_DATA: if (accept_c && word_done_c && last_word_c) state_d = S_TAIL;
`ifdef LOADER_CHECKSUM_EN
         S_CHK: if (accept_c) state_d = (byte_data == xor_q) ? S_DONE : S_ERROR;
`endif
         S_DONE:  state_d = S_RUN;
         S_RUN:   state_d = S_RUN;
         S_ERROR: state_d = S_ERROR;
         default: state_d = S_ERROR;
      endcase
   end

   // Status outputs; release follows the registered state so start trails the last write
   always_comb begin
      byte_ready_d = 1'b0;
      error_d      = 1'b0;
      cpu_reset_d  = 1'b1;
      start_d      = 1'b0;
      load_done_d  = 1'b0;
      case (state_d)
         S_LEN_HI, S_LEN_LO, S_DATA: byte_ready_d = 1'b1;
`ifdef LOADER_CHECKSUM_EN
         S_CHK:                      byte_ready_d = 1'b1;
`endif
         default:                    byte_ready_d = 1'b0;
      endcase
      error_d = (state_d == S_ERROR);
      if (state_q == S_RUN) begin
         cpu_reset_d = 1'b0;
         start_d     = 1'b1;
         load_done_d = 1'b1;
      end
   end

   // Length capture, word assembly and write-port staging
   always_comb begin
      count_d      = count_q;
      word_idx_d   = word_idx_q;
      byte_cnt_d   = byte_cnt_q;
      asm_d        = asm_q;
`ifdef LOADER_CHECKSUM_EN
      xor_d        = xor_q;
`endif
      imem_we_d    = 1'b0;
      imem_addr_d  = imem_addr_q;
      imem_wdata_d = imem_wdata_q;
      if (accept_c) begin
         case (state_q)
            S_LEN_HI: begin
               count_d[15:8] = byte_data;
               word_idx_d    = '0;
               byte_cnt_d    = '0;
`ifdef LOADER_CHECKSUM_EN
               xor_d         = '0;
`endif
            end
            S_LEN_LO: count_d = len_c;
            S_DATA: begin
               asm_d      = {asm_q[15:0], byte_data};
               byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
               xor_d      = xor_q ^ byte_data;
`endif
               if (word_done_c) begin
                  imem_we_d    = 1'b1;
                  imem_addr_d  = word_idx_q[ADDR_WIDTH-1:0];
                  imem_wdata_d = {asm_q, byte_data};
                  word_idx_d   = word_idx_q + IW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         count_q      <= '0;
         word_idx_q   <= '0;
         byte_cnt_q   <= '0;
         asm_q        <= '0;
`ifdef LOADER_CHECKSUM_EN
         xor_q        <= '0;
`endif
         byte_ready_q <= 1'b0;
         imem_we_q    <= 1'b0;
         imem_addr_q  <= '0;
         imem_wdata_q <= '0;
         cpu_reset_q  <= 1'b1;
         start_q      <= 1'b0;
         load_done_q  <= 1'b0;
         error_q      <= 1'b0;
      end else begin
         count_q      <= count_d;
         word_idx_q   <= word_idx_d;
         byte_cnt_q   <= byte_cnt_d;
         asm_q        <= asm_d;
`ifdef LOADER_CHECKSUM_EN
         xor_q        <= xor_d;
`endif
         byte_ready_q <= byte_ready_d;
         imem_we_q    <= imem_we_d;
         imem_addr_q  <= imem_addr_d;
         imem_wdata_q <= imem_wdata_d;
         cpu_reset_q  <= cpu_reset_d;
         start_q      <= start_d;
         load_done_q  <= load_done_d;
         error_q      <= error_d;
      end
   end

   assign byte_ready      = byte_ready_q;
   assign imem_we         = imem_we_q;
   assign imem_addr       = imem_addr_q;
   assign imem_wdata      = imem_wdata_q;
   assign cpu_reset       = cpu_reset_q;
   assign start           = start_q;
   assign load_done       = load_done_q;
   assign error           = error_q;
   assign program_counter = START_PC;

endmodule
